// File: rtl/fp_cmp_minmax_pipe_if.sv
// Handshake bundle for fp_cmp_minmax_pipe: operation request channel and result channel.
// The master modport is the issuing side; the slave modport is the comparator.
interface fp_cmp_minmax_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic             out_invalid;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_invalid, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_invalid, out_tag
    );
endinterface

// File: rtl/fp_cmp_minmax_pipe.sv
// Pipelined IEEE-754 comparator (LE/LT/EQ) and MIN/MAX for any EXP_W/MAN_W format, tag passthrough.
// Optional macro FCLASS_EN enables op 110 (one-hot classification of operand a).
module fp_cmp_minmax_pipe #(
    parameter int EXP_W       = 8,
    parameter int MAN_W       = 23,
    parameter int PIPE_STAGES = 2,   // legal range 1..4
    parameter int TAG_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_cmp_minmax_pipe_if.slave  bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] OP_LE  = 3'b000;
    localparam logic [2:0] OP_LT  = 3'b001;
    localparam logic [2:0] OP_EQ  = 3'b010;
    localparam logic [2:0] OP_MIN = 3'b100;
    localparam logic [2:0] OP_MAX = 3'b101;

    localparam logic [W-1:0] CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [W-2:0]     a_mag, b_mag;
    logic             a_nan, b_nan, a_snan, b_snan;
    logic             a_zero, b_zero;

    assign a_sign = bus.in_a[W-1];
    assign b_sign = bus.in_b[W-1];
    assign a_exp  = bus.in_a[W-2:MAN_W];
    assign b_exp  = bus.in_b[W-2:MAN_W];
    assign a_man  = bus.in_a[MAN_W-1:0];
    assign b_man  = bus.in_b[MAN_W-1:0];
    assign a_mag  = bus.in_a[W-2:0];
    assign b_mag  = bus.in_b[W-2:0];

    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);
    assign a_snan = a_nan && !a_man[MAN_W-1];
    assign b_snan = b_nan && !b_man[MAN_W-1];
    assign a_zero = (a_mag == '0);
    assign b_zero = (b_mag == '0);

    // ------------------------------------------------------------------
    // Ordering. a_below_b/b_below_a form a total order on non-NaN values
    // in which -0 sorts below +0; the IEEE compares then merge the zeros.
    // ------------------------------------------------------------------
    logic mag_a_lt_b, mag_b_lt_a;
    logic a_below_b, b_below_a;
    logic both_zero, any_nan, any_snan;
    logic cmp_lt, cmp_eq, cmp_le;

    assign mag_a_lt_b = (a_mag < b_mag);
    assign mag_b_lt_a = (b_mag < a_mag);
    assign a_below_b  = (a_sign != b_sign) ? a_sign : (a_sign ? mag_b_lt_a : mag_a_lt_b);
    assign b_below_a  = (a_sign != b_sign) ? b_sign : (a_sign ? mag_a_lt_b : mag_b_lt_a);

    assign both_zero = a_zero && b_zero;
    assign any_nan   = a_nan || b_nan;
    assign any_snan  = a_snan || b_snan;

    assign cmp_lt = !any_nan && a_below_b && !both_zero;
    assign cmp_eq = !any_nan && ((bus.in_a == bus.in_b) || both_zero);
    assign cmp_le = cmp_lt || cmp_eq;

`ifdef FCLASS_EN
    localparam logic [2:0] OP_CLASS = 3'b110;

    logic       a_exp_zero, a_inf;
    logic [9:0] a_class;

    assign a_exp_zero = (a_exp == '0);
    assign a_inf      = (&a_exp) && !(|a_man);

    // Bit order: -inf, -normal, -subnormal, -0, +0, +subnormal, +normal, +inf, sNaN, qNaN
    always_comb begin
        a_class = '0;
        if (a_nan) begin
            if (a_snan) a_class[8] = 1'b1;
            else        a_class[9] = 1'b1;
        end else if (a_zero) begin
            if (a_sign) a_class[3] = 1'b1;
            else        a_class[4] = 1'b1;
        end else if (a_inf) begin
            if (a_sign) a_class[0] = 1'b1;
            else        a_class[7] = 1'b1;
        end else if (a_exp_zero) begin
            if (a_sign) a_class[2] = 1'b1;
            else        a_class[5] = 1'b1;
        end else begin
            if (a_sign) a_class[1] = 1'b1;
            else        a_class[6] = 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage-0 result selection
    // ------------------------------------------------------------------
    logic [W-1:0] s0_result;
    logic         s0_invalid;

    always_comb begin
        s0_result  = '0;
        s0_invalid = 1'b0;
        case (bus.in_op)
            OP_LE: begin
                s0_result  = {{(W-1){1'b0}}, cmp_le};
                s0_invalid = any_nan;
            end
            OP_LT: begin
                s0_result  = {{(W-1){1'b0}}, cmp_lt};
                s0_invalid = any_nan;
            end
            OP_EQ: begin
                s0_result  = {{(W-1){1'b0}}, cmp_eq};
                s0_invalid = any_snan;
            end
            OP_MIN, OP_MAX: begin
                s0_invalid = any_snan;
                if (a_nan && b_nan)
                    s0_result = CANON_QNAN;
                else if (a_nan)
                    s0_result = bus.in_b;
                else if (b_nan)
                    s0_result = bus.in_a;
                else if (bus.in_op == OP_MIN)
                    s0_result = b_below_a ? bus.in_b : bus.in_a;   // ties return a
                else
                    s0_result = a_below_b ? bus.in_b : bus.in_a;
            end
`ifdef FCLASS_EN
            OP_CLASS: begin
                s0_result = {{(W-10){1'b0}}, a_class};
            end
`endif
            default: begin
                s0_result  = '0;
                s0_invalid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Elastic pipeline: a stage loads when empty or when its successor
    // loads, so bubbles collapse and a full pipe still streams 1/cycle.
    // ------------------------------------------------------------------
    logic [PIPE_STAGES-1:0]            stage_valid;
    logic [PIPE_STAGES-1:0]            stage_load;
    logic [PIPE_STAGES-1:0][W-1:0]     stage_result;
    logic [PIPE_STAGES-1:0]            stage_invalid;
    logic [PIPE_STAGES-1:0][TAG_W-1:0] stage_tag;

    always_comb begin : load_chain
        logic downstream_ready;
        downstream_ready = bus.out_ready;
        stage_load       = '0;
        for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
            stage_load[i]    = !stage_valid[i] || downstream_ready;
            downstream_ready = stage_load[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            logic             up_valid;
            logic [W-1:0]     up_result;
            logic             up_invalid;
            logic [TAG_W-1:0] up_tag;

            logic             valid_reg;
            logic [W-1:0]     result_reg;
            logic             invalid_reg;
            logic [TAG_W-1:0] tag_reg;

            if (gi == 0) begin : g_head
                assign up_valid   = bus.in_valid;
                assign up_result  = s0_result;
                assign up_invalid = s0_invalid;
                assign up_tag     = bus.in_tag;
            end else begin : g_body
                assign up_valid   = stage_valid[gi-1];
                assign up_result  = stage_result[gi-1];
                assign up_invalid = stage_invalid[gi-1];
                assign up_tag     = stage_tag[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg   <= 1'b0;
                    result_reg  <= '0;
                    invalid_reg <= 1'b0;
                    tag_reg     <= '0;
                end else if (stage_load[gi]) begin
                    valid_reg <= up_valid;
                    if (up_valid) begin
                        result_reg  <= up_result;
                        invalid_reg <= up_invalid;
                        tag_reg     <= up_tag;
                    end
                end
            end

            assign stage_valid[gi]   = valid_reg;
            assign stage_result[gi]  = result_reg;
            assign stage_invalid[gi] = invalid_reg;
            assign stage_tag[gi]     = tag_reg;
        end
    endgenerate

    assign bus.in_ready    = stage_load[0];
    assign bus.out_valid   = stage_valid[PIPE_STAGES-1];
    assign bus.out_result  = stage_result[PIPE_STAGES-1];
    assign bus.out_invalid = stage_invalid[PIPE_STAGES-1];
    assign bus.out_tag     = stage_tag[PIPE_STAGES-1];

endmodule

// File: tb/tb_fp_cmp_minmax_pipe.sv
// Self-checking bench for fp_cmp_minmax_pipe: directed scenarios plus randomized traffic
// checked against a real-valued reference model and an in-order scoreboard.
module tb_fp_cmp_minmax_pipe;
    localparam int EXP_W       = 8;
    localparam int MAN_W       = 23;
    localparam int PIPE_STAGES = 2;
    localparam int TAG_W       = 5;

    localparam logic [2:0] OP_LE  = 3'b000;
    localparam logic [2:0] OP_LT  = 3'b001;
    localparam logic [2:0] OP_EQ  = 3'b010;
    localparam logic [2:0] OP_MIN = 3'b100;
    localparam logic [2:0] OP_MAX = 3'b101;
    localparam logic [2:0] OP_CLS = 3'b110;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int tests_run    = 0;
    int tests_failed = 0;

    fp_cmp_minmax_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

    fp_cmp_minmax_pipe #(
        .EXP_W(EXP_W), .MAN_W(MAN_W), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] specials [12] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                   32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0001, 32'h0000_0001,
                                   32'h8000_0001, 32'h3F80_0000, 32'hBF80_0000, 32'h007F_FFFF};
    logic [2:0] op_pool [8] = '{OP_LE, OP_LT, OP_EQ, OP_MIN, OP_MAX, OP_CLS, 3'b011, 3'b111};

    // ---------------- reference model ----------------
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    // Numeric value of a non-NaN single; infinities map to a huge finite stand-in.
    function automatic real fp_value(input logic [31:0] x);
        real mag;
        int  e;
        e = int'(x[30:23]);
        if (e == 255)    mag = 1.0e300;
        else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
        else             mag = real'({1'b1, x[22:0]}) * (2.0 ** real'(e - 150));
        return x[31] ? -mag : mag;
    endfunction

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic inv);
        real ra, rb;
        bit  an, bn;
        int  idx;
        an  = is_nan(a);
        bn  = is_nan(b);
        ra  = fp_value(a);
        rb  = fp_value(b);
        res = 32'd0;
        inv = 1'b0;
        idx = 0;
        case (op)
            OP_LE: begin res[0] = !(an || bn) && (ra <= rb); inv = an || bn; end
            OP_LT: begin res[0] = !(an || bn) && (ra < rb);  inv = an || bn; end
            OP_EQ: begin res[0] = !(an || bn) && (ra == rb); inv = is_snan(a) || is_snan(b); end
            OP_MIN, OP_MAX: begin
                inv = is_snan(a) || is_snan(b);
                if (an && bn)                          res = 32'h7FC0_0000;
                else if (an)                           res = b;
                else if (bn)                           res = a;
                else if (ra == rb && a[31] != b[31])   res = ((op == OP_MIN) == a[31]) ? a : b;
                else if (op == OP_MIN)                 res = (rb < ra) ? b : a;
                else                                   res = (rb > ra) ? b : a;
            end
`ifdef FCLASS_EN
            OP_CLS: begin
                if (an)                       idx = is_snan(a) ? 8 : 9;
                else if (a[30:0] == 31'd0)    idx = a[31] ? 3 : 4;
                else if (a[30:23] == 8'hFF)   idx = a[31] ? 0 : 7;
                else if (a[30:23] == 8'h00)   idx = a[31] ? 2 : 5;
                else                          idx = a[31] ? 1 : 6;
                res = 32'd1 << idx;
            end
`endif
            default: begin res = 32'd0; inv = 1'b0; end
        endcase
    endfunction

    function automatic logic [31:0] rand_fp(input logic [31:0] other);
        case ($urandom_range(0, 9))
            0, 1:    return specials[$urandom_range(0, 11)];
            2:       return {1'($urandom), 8'h00, 23'($urandom)};
            3:       return other;
            4:       return other ^ 32'h8000_0000;
            5:       return other + 32'd1;
            6:       return {1'($urandom), 8'hFF, 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver (single op, out_ready held high) ----------------
    task automatic run_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, output logic [31:0] res, output logic inv,
                           output logic [4:0] otag, output int lat, output bit timed_out);
        int guard;
        timed_out = 1'b0;
        lat = 0;
        res = '0; inv = 1'b0; otag = '0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk); #1; guard++;
        end
        if (!bus.in_ready) begin
            timed_out = 1'b1;
            bus.in_valid = 1'b0;
            return;
        end
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            lat++;
        end while (!bus.out_valid && lat < 20);
        if (!bus.out_valid) timed_out = 1'b1;
        res  = bus.out_result;
        inv  = bus.out_invalid;
        otag = bus.out_tag;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        tests_run++; if (bus.out_result !== 32'd0) begin tests_failed++; $display("FAIL reset_out_result got=%h want=0", bus.out_result); end
        tests_run++; if (bus.out_invalid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_invalid got=%b want=0", bus.out_invalid); end
        tests_run++; if (bus.out_tag !== 5'd0) begin tests_failed++; $display("FAIL reset_out_tag got=%0d want=0", bus.out_tag); end
        rst_n = 1'b1;
        #1;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_eq_zero_latency();
        logic [31:0] r; logic v; logic [4:0] t; int lat; bit to;
        run_one(OP_EQ, 32'h8000_0000, 32'h0000_0000, 5'd3, r, v, t, lat, to);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL eqz_timeout got=%b want=0", to); end
        tests_run++; if (lat != PIPE_STAGES) begin tests_failed++; $display("FAIL eqz_latency got=%0d want=%0d", lat, PIPE_STAGES); end
        tests_run++; if (r !== 32'd1) begin tests_failed++; $display("FAIL eqz_result got=%h want=00000001", r); end
        tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL eqz_invalid got=%b want=0", v); end
        tests_run++; if (t !== 5'd3) begin tests_failed++; $display("FAIL eqz_tag got=%0d want=3", t); end
    endtask

    task automatic test_nan_compare();
        logic [31:0] r; logic v; logic [4:0] t; int lat; bit to;
        run_one(OP_LT, 32'h7FC0_0000, 32'h3F80_0000, 5'd4, r, v, t, lat, to);
        tests_run++; if (r !== 32'd0 || to) begin tests_failed++; $display("FAIL lt_qnan_result got=%h want=00000000", r); end
        tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL lt_qnan_invalid got=%b want=1", v); end
        run_one(OP_EQ, 32'h7FC0_0000, 32'h3F80_0000, 5'd5, r, v, t, lat, to);
        tests_run++; if (r !== 32'd0 || to) begin tests_failed++; $display("FAIL eq_qnan_result got=%h want=00000000", r); end
        tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL eq_qnan_invalid got=%b want=0", v); end
    endtask

    task automatic test_minmax();
        logic [31:0] r; logic v; logic [4:0] t; int lat; bit to;
        run_one(OP_MIN, 32'h0000_0000, 32'h8000_0000, 5'd6, r, v, t, lat, to);
        tests_run++; if (r !== 32'h8000_0000 || to) begin tests_failed++; $display("FAIL min_zeros got=%h want=80000000", r); end
        run_one(OP_MAX, 32'h7F80_0001, 32'h4000_0000, 5'd7, r, v, t, lat, to);
        tests_run++; if (r !== 32'h4000_0000 || to) begin tests_failed++; $display("FAIL max_snan_result got=%h want=40000000", r); end
        tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL max_snan_invalid got=%b want=1", v); end
        run_one(OP_MIN, 32'h7FC0_0000, 32'hFF80_0001, 5'd8, r, v, t, lat, to);
        tests_run++; if (r !== 32'h7FC0_0000 || to) begin tests_failed++; $display("FAIL min_two_nan got=%h want=7fc00000", r); end
        run_one(OP_MAX, 32'h8000_0000, 32'h0000_0000, 5'd9, r, v, t, lat, to);
        tests_run++; if (r !== 32'h0000_0000 || to) begin tests_failed++; $display("FAIL max_zeros got=%h want=00000000", r); end
    endtask

    task automatic test_order();
        logic [31:0] r; logic v; logic [4:0] t; int lat; bit to;
        run_one(OP_LE, 32'hC000_0000, 32'hBF80_0000, 5'd10, r, v, t, lat, to);
        tests_run++; if (r !== 32'd1 || to) begin tests_failed++; $display("FAIL le_negative got=%h want=00000001", r); end
        run_one(OP_LT, 32'h0000_0001, 32'h0000_0002, 5'd11, r, v, t, lat, to);
        tests_run++; if (r !== 32'd1 || to) begin tests_failed++; $display("FAIL lt_denormal got=%h want=00000001", r); end
        run_one(OP_LT, 32'hBF80_0000, 32'hC000_0000, 5'd12, r, v, t, lat, to);
        tests_run++; if (r !== 32'd0 || to) begin tests_failed++; $display("FAIL lt_negative_rev got=%h want=00000000", r); end
    endtask

    task automatic test_class();
        logic [31:0] r; logic v; logic [4:0] t; int lat; bit to;
`ifdef FCLASS_EN
        run_one(OP_CLS, 32'hFF80_0000, 32'h0, 5'd13, r, v, t, lat, to);
        tests_run++; if (r !== 32'h001 || to) begin tests_failed++; $display("FAIL class_neg_inf got=%h want=00000001", r); end
        run_one(OP_CLS, 32'h7F80_0001, 32'h0, 5'd14, r, v, t, lat, to);
        tests_run++; if (r !== 32'h100 || to) begin tests_failed++; $display("FAIL class_snan got=%h want=00000100", r); end
`else
        run_one(OP_CLS, 32'hFF80_0000, 32'h0, 5'd13, r, v, t, lat, to);
        tests_run++; if (r !== 32'h0 || to) begin tests_failed++; $display("FAIL class_disabled got=%h want=00000000", r); end
`endif
        run_one(3'b111, 32'h7F80_0001, 32'h7F80_0001, 5'd15, r, v, t, lat, to);
        tests_run++; if (r !== 32'h0 || v !== 1'b0 || lat != PIPE_STAGES) begin tests_failed++; $display("FAIL unlisted_op got=%h/%b lat=%0d want=0/0 lat=%0d", r, v, lat, PIPE_STAGES); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops  [3] = '{OP_MAX, OP_LT, OP_MIN};
        logic [31:0] as   [3] = '{32'h3F80_0000, 32'hC000_0000, 32'h0000_0001};
        logic [31:0] bs   [3] = '{32'h4040_0000, 32'h3F80_0000, 32'h8000_0001};
        logic [4:0]  tags [3] = '{5'd20, 5'd21, 5'd22};
        logic [31:0] er [3];
        logic        ei [3];
        for (int k = 0; k < 3; k++) model(ops[k], as[k], bs[k], er[k], ei[k]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1; bus.in_op = ops[k]; bus.in_a = as[k]; bus.in_b = bs[k]; bus.in_tag = tags[k];
            #1;
            tests_run++;
            if (bus.in_ready !== (k < 2)) begin tests_failed++; $display("FAIL b2b_in_ready_%0d got=%b want=%b", k, bus.in_ready, (k < 2)); end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== er[0] || bus.out_tag !== tags[0] || bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_stall_%0d got v=%b r=%h t=%0d rdy=%b want v=1 r=%h t=%0d rdy=0",
                         c, bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready, er[0], tags[0]);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept_on_drain got=%b want=1", bus.in_ready); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                #1;
            end
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== er[k] || bus.out_invalid !== ei[k] || bus.out_tag !== tags[k]) begin
                tests_failed++;
                $display("FAIL b2b_drain_%0d got v=%b r=%h i=%b t=%0d want v=1 r=%h i=%b t=%0d",
                         k, bus.out_valid, bus.out_result, bus.out_invalid, bus.out_tag, er[k], ei[k], tags[k]);
            end
        end
        @(negedge clk); #1;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_duplicate got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r, er; logic v, ei; logic [4:0] t; int lat; bit to;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1; bus.in_op = OP_LE; bus.in_a = 32'h3F80_0000; bus.in_b = 32'h4000_0000; bus.in_tag = 5'(25 + k);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_precondition got=%b want=1", bus.out_valid); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_immediate got=%b want=0", bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stale_%0d got=%b want=0", c, bus.out_valid); end
        end
        model(OP_MAX, 32'hC1200000, 32'h80000000, er, ei);
        run_one(OP_MAX, 32'hC1200000, 32'h80000000, 5'd30, r, v, t, lat, to);
        tests_run++; if (r !== er || t !== 5'd30 || to) begin tests_failed++; $display("FAIL rstmid_recover got=%h/%0d want=%h/30", r, t, er); end
    endtask

    task automatic test_random(input int n_ops);
        logic [31:0] q_res [$];
        logic        q_inv [$];
        logic [4:0]  q_tag [$];
        logic [31:0] er, a, b, pr;
        logic        ei, pi;
        logic [4:0]  pt;
        int issued = 0, cycles = 0;
        bit taken = 1'b0;
        bus.in_valid = 1'b0;
        while ((issued < n_ops || q_res.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (taken) begin bus.in_valid = 1'b0; taken = 1'b0; end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && issued < n_ops && $urandom_range(0, 4) != 0) begin
                a = rand_fp($urandom);
                b = rand_fp(a);
                bus.in_valid = 1'b1;
                bus.in_op  = op_pool[$urandom_range(0, 7)];
                bus.in_a   = a;
                bus.in_b   = b;
                bus.in_tag = 5'($urandom);
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                model(bus.in_op, bus.in_a, bus.in_b, er, ei);
                q_res.push_back(er); q_inv.push_back(ei); q_tag.push_back(bus.in_tag);
                issued++;
                taken = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                tests_run++;
                if (q_res.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_unexpected_output r=%h t=%0d want no output", bus.out_result, bus.out_tag);
                end else begin
                    pr = q_res.pop_front(); pi = q_inv.pop_front(); pt = q_tag.pop_front();
                    if (bus.out_result !== pr || bus.out_invalid !== pi || bus.out_tag !== pt) begin
                        tests_failed++;
                        $display("FAIL rand_result got r=%h i=%b t=%0d want r=%h i=%b t=%0d",
                                 bus.out_result, bus.out_invalid, bus.out_tag, pr, pi, pt);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (issued != n_ops || q_res.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_completion issued=%0d pending=%0d want issued=%0d pending=0", issued, q_res.size(), n_ops);
        end
    endtask

    initial begin
        test_reset();
        test_eq_zero_latency();
        test_nan_compare();
        test_minmax();
        test_order();
        test_class();
        test_back_to_back();
        test_reset_midflight();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
